// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings for the ALU issue controller: op fields, one-hot ALU opcodes,
// FSM states and the instruction/write-back payload layouts.
package alu_issue_ctrl_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned OPC_W   = 11;
    localparam int unsigned NREG    = 8;
    localparam int unsigned RA_W    = 3;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned IMM_W   = 9;
    localparam int unsigned INSTR_W = 16;

    // 4-bit op field values
    localparam logic [OP_W-1:0] OP_NOOP = 4'd0;
    localparam logic [OP_W-1:0] OP_CPY  = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd3;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd4;
    localparam logic [OP_W-1:0] OP_AND  = 4'd5;
    localparam logic [OP_W-1:0] OP_OR   = 4'd6;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd7;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd8;
    localparam logic [OP_W-1:0] OP_LS   = 4'd9;
    localparam logic [OP_W-1:0] OP_RS   = 4'd10;
    localparam logic [OP_W-1:0] OP_ZERO = 4'd11;
    localparam logic [OP_W-1:0] OP_NOR  = 4'd12;
    localparam logic [OP_W-1:0] OP_XNOR = 4'd13;
    localparam logic [OP_W-1:0] OP_NAND = 4'd14;
    localparam logic [OP_W-1:0] OP_LDI  = 4'd15;

    // One-hot ALU opcodes; the last four are the ALU's multi-bit composite codes
    localparam logic [OPC_W-1:0] OPC_NOOP = 11'b00000000001;
    localparam logic [OPC_W-1:0] OPC_CPY  = 11'b00000000010;
    localparam logic [OPC_W-1:0] OPC_ADD  = 11'b00000000100;
    localparam logic [OPC_W-1:0] OPC_SUB  = 11'b00000001000;
    localparam logic [OPC_W-1:0] OPC_MUL  = 11'b00000010000;
    localparam logic [OPC_W-1:0] OPC_AND  = 11'b00000100000;
    localparam logic [OPC_W-1:0] OPC_OR   = 11'b00001000000;
    localparam logic [OPC_W-1:0] OPC_NOT  = 11'b00010000000;
    localparam logic [OPC_W-1:0] OPC_XOR  = 11'b00100000000;
    localparam logic [OPC_W-1:0] OPC_LS   = 11'b01000000000;
    localparam logic [OPC_W-1:0] OPC_RS   = 11'b10000000000;
    localparam logic [OPC_W-1:0] OPC_ZERO = 11'b11111111000;
    localparam logic [OPC_W-1:0] OPC_NOR  = 11'b11111111110;
    localparam logic [OPC_W-1:0] OPC_XNOR = 11'b11111111101;
    localparam logic [OPC_W-1:0] OPC_NAND = 11'b11111111011;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    // imm9 overlays ra/rb: ra = imm9[8:6], rb = imm9[5:3]
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [RA_W-1:0]  rd;
        logic [IMM_W-1:0] imm9;
    } instr_t;

    typedef struct packed {
        logic [RA_W-1:0]   addr;
        logic [DATA_W-1:0] data;
    } wb_t;

    // LDI issues as a CPY of the immediate
    function automatic logic [OPC_W-1:0] decode_op(input logic [OP_W-1:0] op);
        logic [OPC_W-1:0] opc;
        opc = OPC_NOOP;
        case (op)
            OP_NOOP: opc = OPC_NOOP;
            OP_CPY:  opc = OPC_CPY;
            OP_ADD:  opc = OPC_ADD;
            OP_SUB:  opc = OPC_SUB;
            OP_MUL:  opc = OPC_MUL;
            OP_AND:  opc = OPC_AND;
            OP_OR:   opc = OPC_OR;
            OP_NOT:  opc = OPC_NOT;
            OP_XOR:  opc = OPC_XOR;
            OP_LS:   opc = OPC_LS;
            OP_RS:   opc = OPC_RS;
            OP_ZERO: opc = OPC_ZERO;
            OP_NOR:  opc = OPC_NOR;
            OP_XNOR: opc = OPC_XNOR;
            OP_NAND: opc = OPC_NAND;
            OP_LDI:  opc = OPC_CPY;
            default: opc = OPC_NOOP;
        endcase
        return opc;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 8x16 register file: one synchronous write port, three combinational read ports
// (two operand reads and one debug read).
module alu_issue_regfile
    import alu_issue_ctrl_pkg::*;
(
    input  logic              clk_n,
    input  logic              rst_n,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [RA_W-1:0]   rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the one-hot-opcode ALU: accepts an instruction, drives the
// ALU for its one-cycle latency, then writes the result back (IDLE -> EXEC -> WB).
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic               clk_n,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [OPC_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_z,
    output logic               wb_valid,
    output logic [RA_W-1:0]    wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic               z_flag,
    input  logic [RA_W-1:0]    dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    instr_t            fields;
    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [RA_W-1:0]   rd_q;
    logic [RA_W-1:0]   rd_next;
    logic              pend_q;
    logic              pend_next;
    wb_t               wb_q;
    wb_t               wb_next;
    logic              wb_valid_next;
    logic              z_next;
    logic              ready_next;
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;
    logic [OPC_W-1:0]  opc_next;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic              rf_we;

    assign fields = instr_t'(instr);

    alu_issue_regfile u_rf (
        .clk_n    (clk_n),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (alu_out),
        .ra_addr  (fields.imm9[8:6]),
        .ra_data  (ra_data),
        .rb_addr  (fields.imm9[5:3]),
        .rb_data  (rb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Next-state and next-output logic
    always_comb begin
        state_next    = state;
        rd_next       = rd_q;
        pend_next     = pend_q;
        wb_next       = wb_q;
        wb_valid_next = 1'b0;
        z_next        = z_flag;
        a_next        = alu_a;
        b_next        = alu_b;
        opc_next      = alu_opcode;
        rf_we         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (instr_valid && instr_ready) begin
                    rd_next   = fields.rd;
                    pend_next = (fields.op != OP_NOOP);
                    opc_next  = decode_op(fields.op);
                    if (fields.op == OP_LDI) begin
                        a_next = DATA_W'(fields.imm9);
                        b_next = '0;
                    end else begin
                        a_next = ra_data;
                        b_next = rb_data;
                    end
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // ALU captures on this edge; NOOP afterwards makes it hold the result
                opc_next   = OPC_NOOP;
                state_next = ST_WB;
            end
            ST_WB: begin
                if (pend_q) begin
                    rf_we         = 1'b1;
                    wb_valid_next = 1'b1;
                    wb_next.addr  = rd_q;
                    wb_next.data  = alu_out;
                    z_next        = alu_z;
                end
                pend_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: begin
                opc_next   = OPC_NOOP;
                pend_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase

        ready_next = (state_next == ST_IDLE);
    end

    always_ff @(posedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rd_q        <= '0;
            pend_q      <= 1'b0;
            wb_q        <= '0;
            wb_valid    <= 1'b0;
            z_flag      <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= OPC_NOOP;
            instr_ready <= 1'b1;
        end else begin
            state       <= state_next;
            rd_q        <= rd_next;
            pend_q      <= pend_next;
            wb_q        <= wb_next;
            wb_valid    <= wb_valid_next;
            z_flag      <= z_next;
            alu_a       <= a_next;
            alu_b       <= b_next;
            alu_opcode  <= opc_next;
            instr_ready <= ready_next;
        end
    end

    assign wb_addr = wb_q.addr;
    assign wb_data = wb_q.data;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: registered ALU stand-in, instruction-level reference
// model checked every cycle, plus directed literal checks.
module tb_alu_issue_ctrl;

    logic        clk_n;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [10:0] alu_opcode;
    logic [15:0] alu_out;
    logic        alu_z;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        z_flag;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_chk  = 0;
    int n_pass = 0;

    alu_issue_ctrl dut (
        .clk_n       (clk_n),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_out     (alu_out),
        .alu_z       (alu_z),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .z_flag      (z_flag),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk_n = 1'b0;
    always #5 clk_n = ~clk_n;

    logic [10:0] opc_tab [16] = '{11'h001, 11'h002, 11'h004, 11'h008, 11'h010, 11'h020,
                                  11'h040, 11'h080, 11'h100, 11'h200, 11'h400, 11'h7F8,
                                  11'h7FE, 11'h7FD, 11'h7FB, 11'h002};

    // ALU stand-in: registered, holds its result while the opcode is NOOP
    logic [15:0] alu_q;
    always @(posedge clk_n or negedge rst_n) begin
        if (!rst_n) alu_q <= 16'h0;
        else begin
            case (alu_opcode)
                11'h002: alu_q <= alu_a;
                11'h004: alu_q <= alu_a + alu_b;
                11'h008: alu_q <= alu_a - alu_b;
                11'h010: alu_q <= alu_a * alu_b;
                11'h020: alu_q <= alu_a & alu_b;
                11'h040: alu_q <= alu_a | alu_b;
                11'h080: alu_q <= ~alu_a;
                11'h100: alu_q <= alu_a ^ alu_b;
                11'h200: alu_q <= alu_a << alu_b;
                11'h400: alu_q <= alu_a >> alu_b;
                11'h7F8: alu_q <= 16'h0;
                11'h7FE: alu_q <= ~(alu_a | alu_b);
                11'h7FD: alu_q <= ~(alu_a ^ alu_b);
                11'h7FB: alu_q <= ~(alu_a & alu_b);
                default: alu_q <= alu_q;
            endcase
        end
    end
    assign alu_out = alu_q;
    assign alu_z   = (alu_q == 16'h0);

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [15:0] ref_fn(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        case (op)
            4'd1, 4'd15: return a;
            4'd2:  return a + b;
            4'd3:  return a - b;
            4'd4:  return a * b;
            4'd5:  return a & b;
            4'd6:  return a | b;
            4'd7:  return ~a;
            4'd8:  return a ^ b;
            4'd9:  return a << b;
            4'd10: return a >> b;
            4'd12: return ~(a | b);
            4'd13: return ~(a ^ b);
            4'd14: return ~(a & b);
            default: return 16'h0;
        endcase
    endfunction

    // Reference model: one instruction in flight, busy for two edges after accept
    logic [15:0] m_rf [8];
    logic        m_z;
    int          m_cnt = 0;
    int          acc_cnt = 0;
    logic [3:0]  m_op;
    logic [2:0]  m_rd;
    logic [15:0] m_a, m_b, m_r;
    logic        exp_wb;
    logic [2:0]  exp_wa;
    logic [15:0] exp_wd;
    logic [10:0] exp_opc;

    always @(posedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
            m_z = 1'b0; m_cnt = 0; exp_wb = 1'b0; exp_wa = 3'd0; exp_wd = 16'h0;
            exp_opc = 11'h001; m_a = 16'h0; m_b = 16'h0; m_op = 4'd0; m_rd = 3'd0;
        end else begin
            exp_wb = 1'b0;
            if (m_cnt == 2) begin
                exp_opc = 11'h001;
                m_cnt = 1;
            end else if (m_cnt == 1) begin
                m_cnt = 0;
                if (m_op != 4'd0) begin
                    m_r = ref_fn(m_op, m_a, m_b);
                    m_rf[m_rd] = m_r;
                    m_z = (m_r == 16'h0);
                    exp_wb = 1'b1; exp_wa = m_rd; exp_wd = m_r;
                end
            end else if (instr_valid) begin
                m_op = instr[15:12];
                m_rd = instr[11:9];
                if (m_op == 4'd15) begin
                    m_a = {7'b0, instr[8:0]};
                    m_b = 16'h0;
                end else begin
                    m_a = m_rf[instr[8:6]];
                    m_b = m_rf[instr[5:3]];
                end
                exp_opc = opc_tab[m_op];
                m_cnt = 2;
                acc_cnt++;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk_n);
            #1;
            if (rst_n === 1'b1) begin
                check("ready", 16'(instr_ready), 16'(m_cnt == 0));
                check("opcode", 16'(alu_opcode), 16'(exp_opc));
                check("wb_valid", 16'(wb_valid), 16'(exp_wb));
                check("z_flag", 16'(z_flag), 16'(m_z));
                check("dbg_data", dbg_data, m_rf[dbg_addr]);
                if (exp_wb) begin
                    check("wb_addr", 16'(wb_addr), 16'(exp_wa));
                    check("wb_data", wb_data, exp_wd);
                end
                if (m_cnt == 2) begin
                    check("alu_a", alu_a, m_a);
                    check("alu_b", alu_b, m_b);
                end
            end
        end
    end

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 3'b000};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [8:0] imm);
        return {4'hF, rd, imm};
    endfunction

    // Presents one instruction, returns at the falling edge after its write-back edge
    task automatic issue(input logic [15:0] ins, output logic [10:0] opc_seen);
        int base;
        int guard;
        base = acc_cnt;
        guard = 0;
        @(negedge clk_n);
        instr = ins;
        instr_valid = 1'b1;
        while (acc_cnt == base && guard < 20) begin
            @(negedge clk_n);
            guard++;
        end
        if (acc_cnt == base) check("accept_timeout", 16'(acc_cnt), 16'(base + 1));
        instr_valid = 1'b0;
        #2 opc_seen = alu_opcode;
        @(negedge clk_n);
        @(negedge clk_n);
    endtask

    task automatic lit_rf(input string name, input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #2 check(name, dbg_data, exp);
        @(negedge clk_n);
    endtask

    logic [10:0] opc;
    logic [15:0] s [4];
    logic [15:0] sweep_lit [4] = '{16'h0000, 16'hF000, 16'hF00F, 16'hFFF0};
    int k, rdy, cyc, guard, base;

    initial begin
        rst_n = 1'b1;
        instr = 16'h0;
        instr_valid = 1'b0;
        dbg_addr = 3'd0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk_n);
        #3 rst_n = 1'b1;
        @(negedge clk_n);
        check("rst_ready", 16'(instr_ready), 16'h1);
        check("rst_opcode", 16'(alu_opcode), 16'h001);
        check("rst_z", 16'(z_flag), 16'h0);
        check("rst_wb_valid", 16'(wb_valid), 16'h0);

        issue(ldi(3'd1, 9'd5), opc);
        check("ldi_exec_opc", 16'(opc), 16'h002);
        check("ldi1_wb_valid", 16'(wb_valid), 16'h1);
        check("ldi1_wb_addr", 16'(wb_addr), 16'h1);
        lit_rf("ldi1_rf", 3'd1, 16'd5);
        issue(ldi(3'd2, 9'd7), opc);
        lit_rf("ldi2_rf", 3'd2, 16'd7);

        issue(mk(4'd2, 3'd3, 3'd1, 3'd2), opc);
        check("add_wb_addr", 16'(wb_addr), 16'd3);
        check("add_wb_data", wb_data, 16'd12);
        check("add_z", 16'(z_flag), 16'h0);
        lit_rf("add_rf", 3'd3, 16'd12);

        issue(mk(4'd3, 3'd4, 3'd1, 3'd1), opc);
        check("sub_wb_data", wb_data, 16'h0);
        check("sub_z", 16'(z_flag), 16'h1);
        issue(16'h0000, opc);
        check("noop_exec_opc", 16'(opc), 16'h001);
        check("noop_wb_valid", 16'(wb_valid), 16'h0);
        check("noop_z", 16'(z_flag), 16'h1);

        issue(ldi(3'd5, 9'd511), opc);
        issue(mk(4'd9, 3'd6, 3'd5, 3'd2), opc);
        lit_rf("ls_rf", 3'd6, 16'hFF80);
        issue(mk(4'd4, 3'd7, 3'd6, 3'd6), opc);
        lit_rf("mul_trunc_rf", 3'd7, 16'h4000);
        check("mul_trunc_z", 16'(z_flag), 16'h0);
        issue(ldi(3'd0, 9'd256), opc);
        issue(mk(4'd4, 3'd7, 3'd0, 3'd0), opc);
        lit_rf("mul_wrap_rf", 3'd7, 16'h0000);
        check("mul_wrap_z", 16'(z_flag), 16'h1);

        // Streamed, dependent instructions with valid held high
        s[0] = ldi(3'd1, 9'd11);
        s[1] = ldi(3'd2, 9'd22);
        s[2] = mk(4'd2, 3'd3, 3'd1, 3'd2);
        s[3] = mk(4'd3, 3'd4, 3'd3, 3'd1);
        base = acc_cnt; k = 0; rdy = 0; cyc = 0; guard = 0;
        @(negedge clk_n);
        instr = s[0];
        instr_valid = 1'b1;
        while (k < 4 && guard < 60) begin
            #1;
            if (instr_ready) rdy++;
            cyc++;
            @(negedge clk_n);
            guard++;
            if (acc_cnt - base > k) begin
                k++;
                if (k < 4) instr = s[k];
            end
        end
        instr_valid = 1'b0;
        check("stream_accepts", 16'(acc_cnt - base), 16'd4);
        check("stream_ready_cycles", 16'(rdy), 16'd4);
        check("stream_cycles", 16'(cyc), 16'd10);
        repeat (2) @(negedge clk_n);
        lit_rf("stream_r1", 3'd1, 16'd11);
        lit_rf("stream_r2", 3'd2, 16'd22);
        lit_rf("stream_r3", 3'd3, 16'd33);
        lit_rf("stream_r4", 3'd4, 16'd22);

        // Decode sweep on r1=00FF, r2=0F0F
        issue(ldi(3'd1, 9'd255), opc);
        issue(ldi(3'd2, 9'd15), opc);
        issue(ldi(3'd4, 9'd8), opc);
        issue(mk(4'd9, 3'd3, 3'd2, 3'd4), opc);
        issue(mk(4'd6, 3'd2, 3'd3, 3'd2), opc);
        lit_rf("sweep_r2", 3'd2, 16'h0F0F);
        for (int op = 0; op < 16; op++) begin
            issue(mk(4'(op), 3'd7, 3'd1, 3'd2), opc);
            check($sformatf("sweep_opc_%0d", op), 16'(opc), 16'(opc_tab[op]));
            if (op >= 11 && op <= 14)
                lit_rf($sformatf("sweep_res_%0d", op), 3'd7, sweep_lit[op - 11]);
        end

        // Reset while an ADD is in EXEC
        issue(ldi(3'd1, 9'd5), opc);
        base = acc_cnt;
        guard = 0;
        @(negedge clk_n);
        instr = mk(4'd2, 3'd1, 3'd1, 3'd1);
        instr_valid = 1'b1;
        while (acc_cnt == base && guard < 20) begin
            @(negedge clk_n);
            guard++;
        end
        instr_valid = 1'b0;
        check("mid_accept", 16'(acc_cnt - base), 16'd1);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_opcode", 16'(alu_opcode), 16'h001);
        check("mid_rst_wb_valid", 16'(wb_valid), 16'h0);
        check("mid_rst_ready", 16'(instr_ready), 16'h1);
        check("mid_rst_alu_a", alu_a, 16'h0);
        @(negedge clk_n);
        #3 rst_n = 1'b1;
        @(negedge clk_n);
        check("post_rst_wb_valid", 16'(wb_valid), 16'h0);
        check("post_rst_ready", 16'(instr_ready), 16'h1);
        for (int i = 0; i < 8; i++) lit_rf($sformatf("post_rst_r%0d", i), 3'(i), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
